// File: rtl/clk_sw_pkg.sv
// Shared types for the muxed-clock switch sequencer: FSM states and the {AB,CD} select pair.
package clk_sw_pkg;

  typedef enum logic [2:0] {IDLE, DRAIN, SWITCH, SETTLE, DONE} clk_sw_state_t;

  typedef struct packed {
    logic ab;
    logic cd;
  } clk_sel_t;

  localparam clk_sel_t CLK_SEL_RST = '0;

endpackage

// File: rtl/clk_switch_ctrl_if.sv
// Requester/mux-side bundle of clk_switch_ctrl; sw_count exists only when CLK_SW_CNT_EN is defined.
interface clk_switch_ctrl_if #(
  parameter int NREQ = 4
`ifdef CLK_SW_CNT_EN
  , parameter int CNTW = 8
`endif
);

  logic [NREQ-1:0]   req;
  logic [2*NREQ-1:0] req_sel;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic              clk_en;
  logic              cntrlAB;
  logic              cntrlCD;
`ifdef CLK_SW_CNT_EN
  logic [CNTW-1:0]   sw_count;
`endif

`ifdef CLK_SW_CNT_EN
  modport master (output req, req_sel,
                  input  gnt, busy, clk_en, cntrlAB, cntrlCD, sw_count);
  modport slave  (input  req, req_sel,
                  output gnt, busy, clk_en, cntrlAB, cntrlCD, sw_count);
`else
  modport master (output req, req_sel,
                  input  gnt, busy, clk_en, cntrlAB, cntrlCD);
  modport slave  (input  req, req_sel,
                  output gnt, busy, clk_en, cntrlAB, cntrlCD);
`endif

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin search: first asserted req at or after ptr, wrapping.
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid,
  output logic [IW-1:0]   idx
);

  // Scan farthest-first so the nearest hit to ptr is the last one written.
  always_comb begin
    int j;
    valid = 1'b0;
    idx   = ptr;
    j     = 0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      j = int'(ptr) + off;
      if (j >= NREQ) j = j - NREQ;
      if (req[IW'(j)]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/clk_switch_ctrl.sv
// Gate / switch / settle / grant sequencer for the AB and CD muxed clocks.
// Optional switch counter enabled by defining CLK_SW_CNT_EN.
module clk_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 4
`ifdef CLK_SW_CNT_EN
  , parameter int CNTW = 8
`endif
) (
  input logic              clk,
  input logic              rst,
  clk_switch_ctrl_if.slave bus
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(SETTLE + 1);

  clk_sw_state_t   state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  clk_sel_t        tgt_q, tgt_d;
  clk_sel_t        sel_q, sel_d;
  logic            clk_en_q, clk_en_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] mask_q, mask_d;

  logic            arb_valid;
  logic [IW-1:0]   arb_idx;
  clk_sel_t        arb_sel;

  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
    return {{(NREQ-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] i);
    return (i == IW'(NREQ - 1)) ? '0 : i + IW'(1);
  endfunction

  // The just-granted requester sits out exactly one IDLE cycle.
  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req   (bus.req & ~mask_q),
    .ptr   (ptr_q),
    .valid (arb_valid),
    .idx   (arb_idx)
  );

  assign arb_sel = clk_sel_t'(bus.req_sel[{arb_idx, 1'b0} +: 2]);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    tgt_d    = tgt_q;
    sel_d    = sel_q;
    clk_en_d = clk_en_q;
    gnt_d    = '0;
    ptr_d    = ptr_q;
    mask_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (arb_valid) begin
          idx_d = arb_idx;
          tgt_d = arb_sel;
          if (arb_sel == sel_q) begin
            state_d = DONE;
            gnt_d   = onehot(arb_idx);
            ptr_d   = next_ptr(arb_idx);
          end else begin
            state_d  = DRAIN;
            clk_en_d = 1'b0;
            cnt_d    = CW'(SETTLE);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(1)) begin
          state_d = SWITCH;
          sel_d   = tgt_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      SWITCH: begin
        state_d = clk_sw_pkg::SETTLE;
        cnt_d   = CW'(SETTLE);
      end
      clk_sw_pkg::SETTLE: begin
        if (cnt_q == CW'(1)) begin
          state_d  = DONE;
          clk_en_d = 1'b1;
          gnt_d    = onehot(idx_q);
          ptr_d    = next_ptr(idx_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        mask_d  = gnt_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= CLK_SEL_RST;
      clk_en_q <= 1'b1;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
      ptr_q    <= '0;
      mask_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      clk_en_q <= clk_en_d;
      gnt_q    <= gnt_d;
      busy_q   <= (state_d != IDLE);
      ptr_q    <= ptr_d;
      mask_q   <= mask_d;
    end
  end

  always_ff @(posedge clk) begin
    idx_q <= idx_d;
    tgt_q <= tgt_d;
  end

`ifdef CLK_SW_CNT_EN
  logic [CNTW-1:0] sw_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_cnt_q <= '0;
    end else if (state_d == SWITCH) begin
      sw_cnt_q <= sw_cnt_q + CNTW'(1);
    end
  end

  assign bus.sw_count = sw_cnt_q;
`endif

  assign bus.gnt     = gnt_q;
  assign bus.busy    = busy_q;
  assign bus.clk_en  = clk_en_q;
  assign bus.cntrlAB = sel_q.ab;
  assign bus.cntrlCD = sel_q.cd;

endmodule

// File: tb/tb_clk_switch_ctrl.sv
// Scoreboard bench for clk_switch_ctrl (NREQ=4, SETTLE=4; CNTW=2 when CLK_SW_CNT_EN is defined).
module tb_clk_switch_ctrl;

  localparam int NREQ   = 4;
  localparam int SETTLE = 4;
`ifdef CLK_SW_CNT_EN
  localparam int CNTW   = 2;
`endif

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [1:0]      sel;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk  = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

`ifdef CLK_SW_CNT_EN
  clk_switch_ctrl_if #(.NREQ(NREQ), .CNTW(CNTW)) bus ();
  clk_switch_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE), .CNTW(CNTW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`else
  clk_switch_ctrl_if #(.NREQ(NREQ)) bus ();
  clk_switch_ctrl #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );
`endif

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic void push(input logic [NREQ-1:0] g, input logic [1:0] s);
    exp_t e;
    e.gnt = g;
    e.sel = s;
    sb_q.push_back(e);
  endfunction

  // Monitor: scoreboard pop on every grant, plus per-cycle select/gate invariant.
  logic [1:0] prev_sel  = 2'b00;
  logic       prev_en   = 1'b1;
  logic       prev_gnt  = 1'b0;
  logic       prev_rst  = 1'b1;

  always @(negedge clk) begin
    exp_t       e;
    logic [1:0] cur_sel;
    cur_sel = {bus.cntrlAB, bus.cntrlCD};
    if (!prev_rst) begin
      check("sel_change_while_clk_en", 32'((cur_sel != prev_sel) && (bus.clk_en || prev_en)), 32'd0);
      if (prev_gnt) check("idle_after_done", 32'(bus.busy), 32'd0);
    end
    if (bus.gnt != '0) begin
      if (sb_q.size() == 0) begin
        check("unexpected_gnt", 32'(bus.gnt), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_gnt", 32'(bus.gnt), 32'(e.gnt));
        check("sb_sel_at_gnt", 32'(cur_sel), 32'(e.sel));
        check("sb_clk_en_at_gnt", 32'(bus.clk_en), 32'd1);
      end
    end
    prev_sel = cur_sel;
    prev_en  = bus.clk_en;
    prev_gnt = (bus.gnt != '0);
    prev_rst = rst;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Returns at the negedge of the grant cycle; k = negedges waited.
  task automatic wait_gnt(input int max_cyc, input logic [NREQ-1:0] exp_g, output int k);
    k = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      k = i;
      if (bus.gnt != '0) break;
    end
    if (bus.gnt == '0) check("gnt_timeout", 32'(bus.gnt), 32'(exp_g));
  endtask

  initial begin
    int k;
`ifdef CLK_SW_CNT_EN
    logic [CNTW-1:0] sw_snap;
    logic [CNTW-1:0] exp_cnt [5];
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
`endif
    rst         = 1'b1;
    bus.req     = '0;
    bus.req_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_clk_en",  32'(bus.clk_en),  32'd1);
    check("rst_cntrlAB", 32'(bus.cntrlAB), 32'd0);
    check("rst_cntrlCD", 32'(bus.cntrlCD), 32'd0);
    check("rst_gnt",     32'(bus.gnt),     32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);

    // Reset during DRAIN aborts with no grant.
    tick();
    bus.req     = 4'b0001;
    bus.req_sel = 8'b0000_0010;
    tick();
    @(negedge clk);
    check("abort_drain_clk_en", 32'(bus.clk_en), 32'd0);
    check("abort_drain_busy",   32'(bus.busy),   32'd1);
    tick();
    do_reset();
    bus.req = '0;
    @(negedge clk);
    check("abort_busy",    32'(bus.busy),    32'd0);
    check("abort_clk_en",  32'(bus.clk_en),  32'd1);
    check("abort_sel",     32'({bus.cntrlAB, bus.cntrlCD}), 32'd0);
    check("abort_gnt",     32'(bus.gnt),     32'd0);
    repeat (12) @(negedge clk);
    check("abort_stays_idle", 32'(bus.busy), 32'd0);

    // Full switch, requester 1 to {AB,CD}=11.
    tick();
    bus.req     = 4'b0010;
    bus.req_sel = 8'b0000_1100;
    push(4'b0010, 2'b11);
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) check("sw_t1_clk_en", 32'(bus.clk_en), 32'd0);
      if (c == 4) check("sw_t4_sel", 32'({bus.cntrlAB, bus.cntrlCD}), 32'd0);
      if (c == 5) check("sw_t5_sel", 32'({bus.cntrlAB, bus.cntrlCD}), 32'd3);
      if (c == 9) check("sw_t9_clk_en", 32'(bus.clk_en), 32'd0);
      if (c == 10) begin
        check("sw_t10_gnt", 32'(bus.gnt), 32'd2);
        check("sw_t10_clk_en", 32'(bus.clk_en), 32'd1);
      end
    end
    bus.req = '0;

    // No-change grant: requester 2 already at 11.
    tick();
`ifdef CLK_SW_CNT_EN
    sw_snap = bus.sw_count;
`endif
    bus.req     = 4'b0100;
    bus.req_sel = 8'b0011_0000;
    push(4'b0100, 2'b11);
    @(posedge clk);
    @(negedge clk);
    check("nochg_gnt",    32'(bus.gnt),    32'd4);
    check("nochg_clk_en", 32'(bus.clk_en), 32'd1);
    check("nochg_busy",   32'(bus.busy),   32'd1);
`ifdef CLK_SW_CNT_EN
    check("nochg_sw_count", 32'(bus.sw_count), 32'(sw_snap));
`endif
    bus.req = '0;

    // req dropped and req_sel changed during SETTLE: original target 00 still applied.
    tick();
    bus.req     = 4'b1000;
    bus.req_sel = 8'b0000_0000;
    push(4'b1000, 2'b00);
    repeat (7) begin
      @(posedge clk);
      @(negedge clk);
    end
    check("midchg_in_settle", 32'(bus.clk_en), 32'd0);
    bus.req     = '0;
    bus.req_sel = 8'hFF;
    wait_gnt(10, 4'b1000, k);
    check("midchg_latency", 32'(k), 32'd3);
    check("midchg_sel", 32'({bus.cntrlAB, bus.cntrlCD}), 32'd0);

    // Round robin with all requests held.
    tick();
    do_reset();
    bus.req     = 4'b1111;
    bus.req_sel = 8'b11_10_10_01;
    push(4'b0001, 2'b01);
    push(4'b0010, 2'b10);
    push(4'b0100, 2'b10);
    push(4'b1000, 2'b11);
    push(4'b0001, 2'b01);
    wait_gnt(20, 4'b0001, k);
    wait_gnt(20, 4'b0010, k);
    wait_gnt(20, 4'b0100, k);
    wait_gnt(20, 4'b1000, k);
    wait_gnt(20, 4'b0001, k);
    bus.req = '0;

    // Five real switches by requester 0; later ones see the one-cycle mask.
    tick();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [1:0] tgt;
      tgt = (i % 2 == 0) ? 2'b10 : 2'b01;
      if (i > 0) tick();
      bus.req     = 4'b0001;
      bus.req_sel = {6'b0, tgt};
      push(4'b0001, tgt);
      wait_gnt(20, 4'b0001, k);
      check("rep_latency", 32'(k), (i == 0) ? 32'd11 : 32'd12);
      bus.req = '0;
`ifdef CLK_SW_CNT_EN
      check("sw_count", 32'(bus.sw_count), 32'(exp_cnt[i]));
`endif
    end

    repeat (4) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
